// File: rtl/winocnn_pkg.sv
// winocnn_pkg: shared scheduler state type, tile geometry constants and stride helper
package winocnn_pkg;
  localparam int BLK_STRIDE = 6;
  localparam int TILE_L = 6;
  localparam int TILE_S = 4;
  localparam int COORD_W = 11;
  typedef enum logic [2:0] {IDLE, FETCH, KICK, WAIT, DONE} sched_state_t;
  // v*6 as (v<<2)+(v<<1); 255*6+5 still fits in COORD_W
  function automatic logic [COORD_W-1:0] times_stride(input logic [7:0] v);
    logic [COORD_W-1:0] x;
    x = {3'b000, v};
    return (x << 2) + (x << 1);
  endfunction
endpackage

// File: rtl/tile_coord_counter.sv
// tile_coord_counter: nested row / tile-x / tile-y counters for the tile walk
module tile_coord_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_inc_row,
  input  logic       i_inc_tile,
  input  logic [2:0] i_len,
  input  logic [7:0] i_w,
  input  logic [7:0] i_h,
  output logic [2:0] o_r,
  output logic [7:0] o_bx,
  output logic [7:0] o_by,
  output logic       o_last_row,
  output logic       o_last_tile
);
  logic w_last_col;
  assign o_last_row  = o_r == i_len - 3'd1;
  assign w_last_col  = o_bx == i_w - 8'd1;
  assign o_last_tile = w_last_col && (o_by == i_h - 8'd1);
  // row within the current tile wraps after the last row
  always_ff @(posedge clk or posedge reset)
    if (reset) o_r <= '0;
    else if (i_clr) o_r <= '0;
    else if (i_inc_row) o_r <= o_last_row ? 3'd0 : o_r + 3'd1;
  // tile origin walks row-major: bx first, then by
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      o_bx <= '0;
      o_by <= '0;
    end else if (i_clr) begin
      o_bx <= '0;
      o_by <= '0;
    end else if (i_inc_tile) begin
      o_bx <= w_last_col ? 8'd0 : o_bx + 8'd1;
      o_by <= w_last_col ? o_by + 8'd1 : o_by;
    end
endmodule

// File: rtl/data_tile_scheduler.sv
// data_tile_scheduler: walks Winograd input tiles, issues row reads and kicks the PE array per tile
module data_tile_scheduler
  import winocnn_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               data_prepare_i,
  input  logic [7:0]         block_width_i,
  input  logic [7:0]         block_height_i,
  input  logic [3:0]         data_id_i,
  input  logic               size_type_i,
  output logic               rd_req_valid_o,
  input  logic               rd_req_ready_i,
  output logic [COORD_W-1:0] rd_row_o,
  output logic [COORD_W-1:0] rd_col_o,
  output logic [2:0]         rd_len_o,
  output logic [3:0]         rd_id_o,
  output logic               compute_start_o,
  input  logic               compute_done_i,
  output logic               loop_finished_o,
  output logic               busy_o
);
  sched_state_t r_state, w_next;
  logic [7:0] r_w, r_h;
  logic [2:0] r_len;
  logic [3:0] r_id;
  logic       r_armed;
  logic       w_start, w_inc_row, w_inc_tile, w_last_row, w_last_tile;
  logic [2:0] w_r;
  logic [7:0] w_bx, w_by;

  tile_coord_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_start),
    .i_inc_row  (w_inc_row),
    .i_inc_tile (w_inc_tile),
    .i_len      (r_len),
    .i_w        (r_w),
    .i_h        (r_h),
    .o_r        (w_r),
    .o_bx       (w_bx),
    .o_by       (w_by),
    .o_last_row (w_last_row),
    .o_last_tile(w_last_tile)
  );

  assign rd_req_valid_o  = r_state == FETCH;
  assign compute_start_o = r_state == KICK;
  assign loop_finished_o = r_state == DONE;
  assign busy_o          = r_state != IDLE;
  assign rd_row_o        = times_stride(w_by) + COORD_W'(w_r);
  assign rd_col_o        = times_stride(w_bx);
  assign rd_len_o        = r_len;
  assign rd_id_o         = r_id;

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;

  // next state and counter strobes
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_inc_row  = 1'b0;
    w_inc_tile = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = r_armed && data_prepare_i;
        w_next  = w_start ? FETCH : IDLE;
      end
      FETCH: begin
        w_inc_row = rd_req_ready_i;
        w_next    = (rd_req_ready_i && w_last_row) ? KICK : FETCH;
      end
      KICK: w_next = WAIT;
      WAIT: begin
        w_inc_tile = compute_done_i && !w_last_tile;
        w_next     = !compute_done_i ? WAIT : w_last_tile ? DONE : FETCH;
      end
      default: w_next = IDLE;
    endcase
  end

  // armed blocks a restart until data_prepare has been seen low in IDLE
  always_ff @(posedge clk or posedge reset)
    if (reset) r_armed <= 1'b1;
    else if (r_state == DONE) r_armed <= 1'b0;
    else if (r_state == IDLE && !data_prepare_i) r_armed <= 1'b1;

  // pass parameters are captured once at start
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_w   <= '0;
      r_h   <= '0;
      r_len <= '0;
      r_id  <= '0;
    end else if (w_start) begin
      r_w   <= (block_width_i == 8'd0) ? 8'd1 : block_width_i;
      r_h   <= (block_height_i == 8'd0) ? 8'd1 : block_height_i;
      r_len <= size_type_i ? 3'(TILE_L) : 3'(TILE_S);
      r_id  <= data_id_i;
    end
endmodule
